serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing diff = a − b, LSB first, one bit per clock, through a single full-subtractor cell and a registered borrow. It is the inverse-operation, sequential counterpart of the team's combinational half/full adder cells. It trades latency for area and sits beside the adder datapath, driven by a start/done handshake from the controlling sequencer.

---
 rtl/serial_subtractor.sv | 181 ++++++++++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned subtractor, diff = a - b (mod 2^WIDTH),
//             processed LSB first, one bit per clock, through a single
//             full-subtractor cell with a registered borrow.
//             A start pulse accepted in IDLE captures both operands. The unit
//             is busy for WIDTH cycles, then pulses done for one cycle with
//             diff/borrow valid. One operation per WIDTH+2 cycles.
//
//  Ports    : clk       rising-edge clock
//             rst       asynchronous active-high reset
//             start_i   request pulse, sampled only in IDLE
//             a_i       minuend, captured on the accepted start edge
//             b_i       subtrahend, captured on the accepted start edge
//             busy_o    high while bits are being processed
//             done_o    one-cycle pulse, diff_o/borrow_o valid from here
//             diff_o    registered result a - b mod 2^WIDTH
//             borrow_o  registered final borrow-out (a < b, unsigned)
//
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o
);

   // Bit counter spans 0..WIDTH-1.
   localparam int            c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

   // Operand width is restricted to 2..32.
   generate
      if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
         $error("serial_subtractor: WIDTH must be in 2..32");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;        // minuend shift register
   logic [WIDTH-1:0]   sb_q, sb_d;        // subtrahend shift register
   // Partial difference. Only the first WIDTH-1 result bits ever need to be
   // stored: the last bit comes straight from the cell when diff is written.
   logic [WIDTH-2:0]   sd_q, sd_d;
   logic               bflop_q, bflop_d;  // running borrow between bits
   logic [c_CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Full-subtractor cell on the current LSBs.
   logic               w_x, w_y, w_bin;
   logic               w_d, w_bout;
   logic [WIDTH-2:0]   w_sd_shift;

   assign w_x    = sa_q[0];
   assign w_y    = sb_q[0];
   assign w_bin  = bflop_q;
   assign w_d    = w_x ^ w_y ^ w_bin;
   assign w_bout = (~w_x & w_y) | (~(w_x ^ w_y) & w_bin);

   // New difference bit enters at the MSB of the partial-difference register
   // while everything else moves one place towards the LSB.
   generate
      if (WIDTH > 2) begin : g_sd_multi
         assign w_sd_shift = {w_d, sd_q[WIDTH-2:1]};
      end else begin : g_sd_single
         assign w_sd_shift = w_d;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sd_d     = sd_q;
      bflop_d  = bflop_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sa_d    = a_i;
               sb_d    = b_i;
               sd_d    = '0;
               bflop_d = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (cnt_q == c_LAST) begin
               // Final bit: publish the full result directly. diff/borrow are
               // only ever written here, so a later start cannot disturb them.
               diff_d   = {w_d, sd_q};
               borrow_d = w_bout;
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end else begin
               sa_d    = sa_q >> 1;
               sb_d    = sb_q >> 1;
               sd_d    = w_sd_shift;
               bflop_d = w_bout;
               cnt_d   = cnt_q + 1'b1;
               busy_d  = 1'b1;
            end
         end

         ST_DONE: begin
            // start is deliberately not examined here: requests are not queued.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sd_q     <= '0;
         bflop_q  <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sd_q     <= sd_d;
         bflop_q  <= bflop_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // All outputs come straight from flops.
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor. Two instances
//             (WIDTH=8 and WIDTH=2) share clock and reset. A per-instance
//             reference model decides which starts are accepted, queues the
//             arithmetic result and predicts busy/done timing; a monitor pops
//             and compares when done is seen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_s [2];
   logic [7:0] a_s     [2];
   logic [7:0] b_s     [2];

   int n_cmp = 0;
   int n_bad = 0;
   int ops   [2];
   int pend  [2];

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chk
         localparam int W = (gi == 0) ? 8 : 2;

         logic         busy, done, borrow;
         logic [W-1:0] diff;

         serial_subtractor #(.WIDTH(W)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start_i  (start_s[gi]),
            .a_i      (a_s[gi][W-1:0]),
            .b_i      (b_s[gi][W-1:0]),
            .busy_o   (busy),
            .done_o   (done),
            .diff_o   (diff),
            .borrow_o (borrow)
         );

         // Reference model: plain arithmetic plus a "next legal start" time.
         logic [W:0] q [$];          // {borrow, diff}
         logic [W:0] held = '0;      // last published result
         logic [W:0] got, want;
         int cyc      = 0;
         int acc_e    = -1000;       // edge of the last accepted start
         int nxt      = 0;           // earliest edge a new start is accepted
         bit exp_busy, exp_done;

         always @(posedge clk) begin
            cyc = cyc + 1;
            if (rst) begin
               q.delete();
               acc_e = -1000;
               nxt   = 0;
               held  = '0;
            end else if (start_s[gi] && cyc >= nxt) begin
               int av, bv;
               av = int'(a_s[gi][W-1:0]);
               bv = int'(b_s[gi][W-1:0]);
               want = {(av < bv), W'((av - bv + (1 << W)) % (1 << W))};
               q.push_back(want);
               acc_e = cyc;
               nxt   = cyc + W + 2;
               ops[gi] = ops[gi] + 1;
            end
            pend[gi] = q.size();

            #1;
            exp_busy = (cyc >= acc_e) && (cyc <= acc_e + W - 1);
            exp_done = (cyc == acc_e + W);

            n_cmp = n_cmp + 1;
            if (busy !== exp_busy) begin
               n_bad = n_bad + 1;
               if (n_bad < 40)
                  $display("FAIL busy W=%0d cyc=%0d got=%b want=%b", W, cyc, busy, exp_busy);
            end
            n_cmp = n_cmp + 1;
            if (done !== exp_done) begin
               n_bad = n_bad + 1;
               if (n_bad < 40)
                  $display("FAIL done W=%0d cyc=%0d got=%b want=%b", W, cyc, done, exp_done);
            end

            got = {borrow, diff};
            if (done === 1'b1) begin
               n_cmp = n_cmp + 1;
               if (q.size() == 0) begin
                  n_bad = n_bad + 1;
                  if (n_bad < 40)
                     $display("FAIL result W=%0d cyc=%0d got=%h want=<none queued>", W, cyc, got);
               end else begin
                  want = q.pop_front();
                  held = want;
                  if (got !== want) begin
                     n_bad = n_bad + 1;
                     if (n_bad < 40)
                        $display("FAIL result W=%0d cyc=%0d got borrow/diff=%h want=%h", W, cyc, got, want);
                  end
               end
               pend[gi] = q.size();
            end

            // Outputs must hold between done pulses (and be zero after reset).
            n_cmp = n_cmp + 1;
            if (got !== held) begin
               n_bad = n_bad + 1;
               if (n_bad < 40)
                  $display("FAIL hold W=%0d cyc=%0d got borrow/diff=%h want=%h", W, cyc, got, held);
            end
         end
      end
   endgenerate

   // Single operation on the WIDTH=8 instance, then wait until it is idle.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start_s[0] = 1'b1;
      a_s[0]     = a;
      b_s[0]     = b;
      @(negedge clk);
      start_s[0] = 1'b0;
      a_s[0]     = 8'($urandom);
      b_s[0]     = 8'($urandom);
      repeat (10) @(negedge clk);
   endtask

   task automatic rand_run(input int idx, input int n);
      int target, guard;
      target = ops[idx] + n;
      guard  = 0;
      while (ops[idx] < target && guard < 40000) begin
         @(negedge clk);
         start_s[idx] = 1'($urandom_range(0, 1));
         a_s[idx]     = 8'($urandom);
         b_s[idx]     = 8'($urandom);
         guard++;
      end
      start_s[idx] = 1'b0;
      n_cmp = n_cmp + 1;
      if (ops[idx] < target) begin
         n_bad = n_bad + 1;
         $display("FAIL rand_ops idx=%0d got=%0d want=%0d", idx, ops[idx], target);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         a_s[i]     = '0;
         b_s[i]     = '0;
         ops[i]     = 0;
         pend[i]    = 0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed cases, including full borrow ripple and equal operands.
      do_op(8'h05, 8'h03);
      do_op(8'h03, 8'h05);
      do_op(8'h00, 8'h01);
      do_op(8'hFF, 8'hFF);
      do_op(8'h00, 8'h00);
      do_op(8'h80, 8'h7F);

      // start held high with operands changing every cycle.
      @(negedge clk);
      start_s[0] = 1'b1;
      repeat (30) begin
         @(negedge clk);
         a_s[0] = 8'($urandom);
         b_s[0] = 8'($urandom);
      end
      start_s[0] = 1'b0;
      repeat (12) @(negedge clk);

      // Abort mid-operation, then confirm a fresh operation still works.
      @(negedge clk);
      start_s[0] = 1'b1;
      a_s[0]     = 8'h9C;
      b_s[0]     = 8'h21;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      do_op(8'h5A, 8'hA5);

      // Randomised traffic on both widths in parallel.
      fork
         rand_run(0, 1000);
         rand_run(1, 1000);
      join
      repeat (20) @(negedge clk);

      for (int i = 0; i < 2; i++) begin
         n_cmp = n_cmp + 1;
         if (pend[i] != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain idx=%0d got=%0d outstanding want=0", i, pend[i]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
